// File: rtl/fnn_pkg.sv
// ============================================================================
// Module   : fnn_pkg
// Purpose  : Shared types and defaults for the neuron weight sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fnn_pkg;

   localparam int FNN_NUM_WEIGHT = 30;
   localparam int FNN_DATA_W     = 16;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_RUN   = 2'd1,
      SEQ_DRAIN = 2'd2,
      SEQ_DONE  = 2'd3
   } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/neuron_weight_sequencer_if.sv
// ============================================================================
// Module   : neuron_weight_sequencer_if
// Purpose  : Control, input stream, weight load, memory and MAC signals of one neuron.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface neuron_weight_sequencer_if
   import fnn_pkg::*;
#(
   parameter int DATA_W = FNN_DATA_W,
   parameter int ADDR_W = $clog2(FNN_NUM_WEIGHT)
);

   logic              start;
   logic              busy;
   logic              done;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              cfg_valid;
   logic [DATA_W-1:0] cfg_data;
   logic              cfg_ready;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_wadd;
   logic [DATA_W-1:0] mem_win;
   logic              mem_ren;
   logic [ADDR_W-1:0] mem_radd;
   logic [DATA_W-1:0] mem_wout;
   logic              mac_valid;
   logic [DATA_W-1:0] mac_x;
   logic [DATA_W-1:0] mac_w;
   logic              mac_last;

   modport slave (
      input  start, in_valid, in_data, cfg_valid, cfg_data, mem_wout,
      output busy, done, in_ready, cfg_ready, mem_wen, mem_wadd, mem_win,
             mem_ren, mem_radd, mac_valid, mac_x, mac_w, mac_last
   );

   modport master (
      output start, in_valid, in_data, cfg_valid, cfg_data, mem_wout,
      input  busy, done, in_ready, cfg_ready, mem_wen, mem_wadd, mem_win,
             mem_ren, mem_radd, mac_valid, mac_x, mac_w, mac_last
   );

endinterface

`default_nettype wire

// File: rtl/fnn_wrap_counter.sv
// ============================================================================
// Module   : fnn_wrap_counter
// Purpose  : Counter 0..MAX that wraps on an explicit compare, not a power-of-2 rollover.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fnn_wrap_counter #(
   parameter int MAX = 29,
   parameter int W   = 5
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic         inc,
   output logic [W-1:0]      cnt,
   output logic              at_max
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      at_max = (cnt_q == W'(MAX));
      cnt_d  = cnt_q;
      if (inc) begin
         cnt_d = at_max ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/neuron_weight_sequencer.sv
// ============================================================================
// Module   : neuron_weight_sequencer
// Purpose  : Streams inputs against a 1-cycle weight memory and loads weights when idle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module neuron_weight_sequencer
   import fnn_pkg::*;
#(
   parameter int NUM_WEIGHT = FNN_NUM_WEIGHT,
   parameter int DATA_W     = FNN_DATA_W,
   parameter int ADDR_W     = $clog2(NUM_WEIGHT)
) (
   input  wire logic                 clk,
   input  wire logic                 rst,
   neuron_weight_sequencer_if.slave  bus
);

   seq_state_t        state_q, state_d;
   logic [DATA_W-1:0] x_pipe_q, x_pipe_d;
   logic              last_pipe_q, last_pipe_d;
   logic              v_pipe_q, v_pipe_d;
   logic              mem_wen_q, mem_wen_d;
   logic [ADDR_W-1:0] mem_wadd_q, mem_wadd_d;
   logic [DATA_W-1:0] mem_win_q, mem_win_d;

   logic              in_ready;
   logic              cfg_ready;
   logic              accept;
   logic              cfg_accept;
   logic [ADDR_W-1:0] rptr;
   logic [ADDR_W-1:0] wptr;
   logic              rptr_at_max;
   logic              wptr_at_max_unused;

   fnn_wrap_counter #(.MAX(NUM_WEIGHT - 1), .W(ADDR_W)) u_rptr (
      .clk    (clk),
      .rst    (rst),
      .inc    (accept),
      .cnt    (rptr),
      .at_max (rptr_at_max)
   );

   fnn_wrap_counter #(.MAX(NUM_WEIGHT - 1), .W(ADDR_W)) u_wptr (
      .clk    (clk),
      .rst    (rst),
      .inc    (cfg_accept),
      .cnt    (wptr),
      .at_max (wptr_at_max_unused)
   );

   always_comb begin
      state_d     = state_q;
      in_ready    = (state_q == SEQ_RUN);
      // start takes priority over a weight word offered in the same cycle
      cfg_ready   = (state_q == SEQ_IDLE) & ~bus.start;
      accept      = bus.in_valid & in_ready;
      cfg_accept  = bus.cfg_valid & cfg_ready;
      x_pipe_d    = accept ? bus.in_data : x_pipe_q;
      last_pipe_d = accept ? rptr_at_max : last_pipe_q;
      v_pipe_d    = accept;
      mem_wen_d   = cfg_accept;
      mem_wadd_d  = cfg_accept ? wptr : mem_wadd_q;
      mem_win_d   = cfg_accept ? bus.cfg_data : mem_win_q;

      case (state_q)
         SEQ_IDLE:  if (bus.start) state_d = SEQ_RUN;
         SEQ_RUN:   if (accept && rptr_at_max) state_d = SEQ_DRAIN;
         SEQ_DRAIN: state_d = SEQ_DONE;
         SEQ_DONE:  state_d = SEQ_IDLE;
         default:   state_d = SEQ_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SEQ_IDLE;
         x_pipe_q    <= '0;
         last_pipe_q <= 1'b0;
         v_pipe_q    <= 1'b0;
         mem_wen_q   <= 1'b0;
         mem_wadd_q  <= '0;
         mem_win_q   <= '0;
      end else begin
         state_q     <= state_d;
         x_pipe_q    <= x_pipe_d;
         last_pipe_q <= last_pipe_d;
         v_pipe_q    <= v_pipe_d;
         mem_wen_q   <= mem_wen_d;
         mem_wadd_q  <= mem_wadd_d;
         mem_win_q   <= mem_win_d;
      end
   end

   assign bus.busy      = (state_q != SEQ_IDLE);
   assign bus.done      = (state_q == SEQ_DONE);
   assign bus.in_ready  = in_ready;
   assign bus.cfg_ready = cfg_ready;
   assign bus.mem_wen   = mem_wen_q;
   assign bus.mem_wadd  = mem_wadd_q;
   assign bus.mem_win   = mem_win_q;
   assign bus.mem_ren   = accept;
   assign bus.mem_radd  = rptr;
   assign bus.mac_valid = v_pipe_q;
   assign bus.mac_x     = x_pipe_q;
   assign bus.mac_w     = bus.mem_wout;
   assign bus.mac_last  = v_pipe_q & last_pipe_q;

endmodule

`default_nettype wire
